// File: rtl/id_scoreboard.sv
// id_scoreboard: per-GPR in-flight writer counters plus a load-pending bit for decode.
// Ports: rs/rt read fields, issue/wb/ld_done/flush events; rs_busy, rt_busy, ld_stall, sb_err; SCBD_PERF_EN adds stall_cycles, ld_stall_events.
module id_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] rs_addr,
  input  logic [4:0] rt_addr,
  input  logic       rs_re,
  input  logic       rt_re,
  input  logic       ds_valid,
  input  logic       issue,
  input  logic       issue_we,
  input  logic [4:0] issue_dest,
  input  logic       issue_load,
  input  logic       ld_done,
  input  logic [4:0] ld_done_dest,
  input  logic       wb_we,
  input  logic [4:0] wb_dest,
  input  logic       flush,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic       ld_stall,
  output logic       sb_err
`ifdef SCBD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] ld_stall_events
`endif
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  lbusy_q, lbusy_d;
  logic             err_q, err_d;

  always_comb begin
    logic inc_r, dec_r, ldc_r;
    cnt_d   = cnt_q;
    lbusy_d = lbusy_q;
    err_d   = err_q;
    inc_r   = 1'b0;
    dec_r   = 1'b0;
    ldc_r   = 1'b0;
    if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_d[r] = '0;
      end
      lbusy_d = '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        inc_r = issue && issue_we && (32'(issue_dest) == r);
        dec_r = wb_we && (32'(wb_dest) == r);
        ldc_r = ld_done && (32'(ld_done_dest) == r);
        // Simultaneous inc and dec cancel out.
        if (inc_r && !dec_r) begin
          if (cnt_q[r] == CMAX) err_d = 1'b1;
          else cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end
        if (dec_r && !inc_r) begin
          if (cnt_q[r] == '0) err_d = 1'b1;
          else cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
        // Issue is the youngest writer, so it overrides a load return.
        if (ldc_r) lbusy_d[r] = 1'b0;
        if (inc_r) lbusy_d[r] = issue_load;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      lbusy_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lbusy_q <= lbusy_d;
      err_q   <= err_d;
    end
  end

  logic rs_lb, rt_lb;

  assign rs_busy = rs_re && (rs_addr != '0)
                && (cnt_q[rs_addr] != '0);
  assign rt_busy = rt_re && (rt_addr != '0)
                && (cnt_q[rt_addr] != '0);

  // A returning load releases its consumer in the same cycle.
  assign rs_lb = lbusy_q[rs_addr]
              && !(ld_done && ld_done_dest == rs_addr);
  assign rt_lb = lbusy_q[rt_addr]
              && !(ld_done && ld_done_dest == rt_addr);

  assign ld_stall = ds_valid
                 && ((rs_busy && rs_lb) || (rt_busy && rt_lb));
  assign sb_err   = err_q;

`ifdef SCBD_PERF_EN
  logic [31:0] stall_cyc_q;
  logic [31:0] stall_evt_q;
  logic        stall_prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cyc_q  <= '0;
      stall_evt_q  <= '0;
      stall_prev_q <= 1'b0;
    end else begin
      if (ld_stall) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (ld_stall && !stall_prev_q) stall_evt_q <= stall_evt_q + 32'd1;
      stall_prev_q <= ld_stall;
    end
  end

  assign stall_cycles    = stall_cyc_q;
  assign ld_stall_events = stall_evt_q;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed scenarios plus random traffic against a
// counter/flag reference model of the register scoreboard.
module tb_id_scoreboard;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] rs_addr, rt_addr, issue_dest, ld_done_dest, wb_dest;
  logic       rs_re, rt_re, ds_valid, issue, issue_we, issue_load;
  logic       ld_done, wb_we, flush;
  logic       rs_busy, rt_busy, ld_stall, sb_err;
`ifdef SCBD_PERF_EN
  logic [31:0] stall_cycles, ld_stall_events;
`endif

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .resetn(resetn),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_re(rs_re), .rt_re(rt_re), .ds_valid(ds_valid),
    .issue(issue), .issue_we(issue_we),
    .issue_dest(issue_dest), .issue_load(issue_load),
    .ld_done(ld_done), .ld_done_dest(ld_done_dest),
    .wb_we(wb_we), .wb_dest(wb_dest), .flush(flush),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .ld_stall(ld_stall), .sb_err(sb_err)
`ifdef SCBD_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .ld_stall_events(ld_stall_events)
`endif
  );

  int total = 0;
  int bad = 0;

  // reference model: in-flight writer count and load-pending flag per GPR
  int m_cnt[32];
  bit m_lb[32];
  bit m_err;

  function automatic bit m_busy(logic [4:0] a, logic re);
    return re && a != 5'd0 && m_cnt[a] != 0;
  endfunction

  function automatic bit m_lbe(logic [4:0] a);
    return m_lb[a] && !(ld_done && ld_done_dest == a);
  endfunction

  function automatic bit m_stall();
    return ds_valid &&
      ((m_busy(rs_addr, rs_re) && m_lbe(rs_addr)) ||
       (m_busy(rt_addr, rt_re) && m_lbe(rt_addr)));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_cnt[r] = 0;
      m_lb[r] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_step();
    if (flush) begin
      for (int r = 0; r < 32; r++) begin
        m_cnt[r] = 0;
        m_lb[r] = 1'b0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        int n;
        bit wr;
        wr = issue && issue_we && issue_dest == 5'(r);
        n = m_cnt[r] + int'(wr) - int'(wb_we && wb_dest == 5'(r));
        if (n > 3) begin n = 3; m_err = 1'b1; end
        if (n < 0) begin n = 0; m_err = 1'b1; end
        m_cnt[r] = n;
        if (ld_done && ld_done_dest == 5'(r)) m_lb[r] = 1'b0;
        if (wr) m_lb[r] = issue_load;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_addr = 0; rt_addr = 0; rs_re = 0; rt_re = 0;
    ds_valid = 0; issue = 0; issue_we = 0; issue_dest = 0;
    issue_load = 0; ld_done = 0; ld_done_dest = 0;
    wb_we = 0; wb_dest = 0; flush = 0;
  endtask

  task automatic do_issue(logic [4:0] d, logic ld);
    issue = 1; issue_we = 1; issue_dest = d; issue_load = ld;
  endtask

  task automatic do_reset();
    idle();
    resetn = 0;
    model_reset();
    #2;
    resetn = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    model_reset();
    rs_re = 1; rt_re = 1; rs_addr = 5; rt_addr = 3; ds_valid = 1;
    #3;
    total++;
    if (rs_busy !== 1'b0) begin
      bad++; $display("FAIL rst_rs_busy got=%b exp=0", rs_busy);
    end
    total++;
    if (rt_busy !== 1'b0) begin
      bad++; $display("FAIL rst_rt_busy got=%b exp=0", rt_busy);
    end
    total++;
    if (ld_stall !== 1'b0) begin
      bad++; $display("FAIL rst_stall got=%b exp=0", ld_stall);
    end
    total++;
    if (sb_err !== 1'b0) begin
      bad++; $display("FAIL rst_err got=%b exp=0", sb_err);
    end
    @(posedge clk);
    #1;
    resetn = 1;
    idle();
  endtask

  task automatic test_load_use();
    idle(); do_issue(5, 1); tick();
    idle(); ds_valid = 1; rs_re = 1; rs_addr = 5; #1;
    total++;
    if (ld_stall !== 1'b1) begin
      bad++; $display("FAIL lu_stall1 got=%b exp=1", ld_stall);
    end
    total++;
    if (rs_busy !== 1'b1) begin
      bad++; $display("FAIL lu_busy1 got=%b exp=1", rs_busy);
    end
    tick();
    total++;
    if (ld_stall !== 1'b1) begin
      bad++; $display("FAIL lu_stall_hold got=%b exp=1", ld_stall);
    end
    ld_done = 1; ld_done_dest = 5; #1;
    total++;
    if (ld_stall !== 1'b0) begin
      bad++; $display("FAIL lu_release got=%b exp=0", ld_stall);
    end
    tick();
    ld_done = 0; #1;
    total++;
    if (ld_stall !== 1'b0 || rs_busy !== 1'b1) begin
      bad++;
      $display("FAIL lu_after got=%b%b exp=01", ld_stall, rs_busy);
    end
    idle(); wb_we = 1; wb_dest = 5; tick();
    idle(); rs_re = 1; rs_addr = 5; #1;
    total++;
    if (rs_busy !== 1'b0) begin
      bad++; $display("FAIL lu_wb got=%b exp=0", rs_busy);
    end
  endtask

  task automatic test_alu_chain();
    idle(); do_issue(3, 0);
    tick(); tick(); tick();
    idle(); ds_valid = 1; rt_re = 1; rt_addr = 3; #1;
    total++;
    if (rt_busy !== 1'b1 || ld_stall !== 1'b0) begin
      bad++;
      $display("FAIL alu_busy got=%b%b exp=10", rt_busy, ld_stall);
    end
    for (int i = 0; i < 3; i++) begin
      wb_we = 1; wb_dest = 3; tick();
      wb_we = 0; #1;
      total++;
      if (rt_busy !== (i < 2)) begin
        bad++;
        $display("FAIL alu_wb%0d got=%b exp=%b", i, rt_busy, i < 2);
      end
    end
    total++;
    if (sb_err !== 1'b0) begin
      bad++; $display("FAIL alu_err got=%b exp=0", sb_err);
    end
  endtask

  task automatic test_simul();
    idle(); do_issue(7, 0); tick();
    wb_we = 1; wb_dest = 7; tick();
    idle(); rs_re = 1; rs_addr = 7; #1;
    total++;
    if (rs_busy !== 1'b1 || sb_err !== 1'b0) begin
      bad++;
      $display("FAIL sim_keep got=%b%b exp=10", rs_busy, sb_err);
    end
    wb_we = 1; wb_dest = 7; tick();
    wb_we = 0; #1;
    total++;
    if (rs_busy !== 1'b0 || sb_err !== 1'b0) begin
      bad++;
      $display("FAIL sim_drain got=%b%b exp=00", rs_busy, sb_err);
    end
  endtask

  task automatic test_flush_reset();
    idle(); do_issue(4, 1); tick(); tick();
    idle(); ds_valid = 1; rs_re = 1; rs_addr = 4; #1;
    total++;
    if (ld_stall !== 1'b1) begin
      bad++; $display("FAIL fl_pre got=%b exp=1", ld_stall);
    end
    flush = 1; do_issue(4, 1); tick();
    idle(); ds_valid = 1; rs_re = 1; rs_addr = 4; #1;
    total++;
    if (rs_busy !== 1'b0 || ld_stall !== 1'b0) begin
      bad++;
      $display("FAIL fl_clear got=%b%b exp=00", rs_busy, ld_stall);
    end
    idle(); do_issue(6, 1); tick();
    idle(); ds_valid = 1; rs_re = 1; rs_addr = 6; #1;
    total++;
    if (ld_stall !== 1'b1) begin
      bad++; $display("FAIL rs_pre got=%b exp=1", ld_stall);
    end
    resetn = 0; #1;
    total++;
    if (ld_stall !== 1'b0 || rs_busy !== 1'b0) begin
      bad++;
      $display("FAIL rs_async got=%b%b exp=00", ld_stall, rs_busy);
    end
    model_reset();
    #1;
    resetn = 1;
    idle();
    tick();
  endtask

  task automatic test_r0_re();
    idle(); do_issue(0, 1); tick();
    idle(); ds_valid = 1; rs_re = 1; rs_addr = 0; #1;
    total++;
    if (rs_busy !== 1'b0 || ld_stall !== 1'b0) begin
      bad++;
      $display("FAIL r0 got=%b%b exp=00", rs_busy, ld_stall);
    end
    idle(); do_issue(8, 1); tick();
    idle(); ds_valid = 1; rt_addr = 8; rt_re = 0; #1;
    total++;
    if (ld_stall !== 1'b0 || rt_busy !== 1'b0) begin
      bad++;
      $display("FAIL re_off got=%b%b exp=00", ld_stall, rt_busy);
    end
    rt_re = 1; #1;
    total++;
    if (ld_stall !== 1'b1) begin
      bad++; $display("FAIL re_on got=%b exp=1", ld_stall);
    end
    idle(); ld_done = 1; ld_done_dest = 8;
    wb_we = 1; wb_dest = 8; tick();
    idle();
  endtask

  task automatic test_overflow();
    idle(); do_issue(9, 0);
    tick(); tick(); tick();
    total++;
    if (sb_err !== 1'b0) begin
      bad++; $display("FAIL ov_pre got=%b exp=0", sb_err);
    end
    tick();
    idle(); #1;
    total++;
    if (sb_err !== 1'b1) begin
      bad++; $display("FAIL ov_set got=%b exp=1", sb_err);
    end
    rs_re = 1; rs_addr = 9;
    wb_we = 1; wb_dest = 9; tick(); tick();
    wb_we = 0; #1;
    total++;
    if (rs_busy !== 1'b1) begin
      bad++; $display("FAIL ov_two got=%b exp=1", rs_busy);
    end
    wb_we = 1; tick();
    wb_we = 0; #1;
    total++;
    if (rs_busy !== 1'b0 || sb_err !== 1'b1) begin
      bad++;
      $display("FAIL ov_sat got=%b%b exp=01", rs_busy, sb_err);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    total++;
    if (sb_err !== 1'b0) begin
      bad++; $display("FAIL uf_pre got=%b exp=0", sb_err);
    end
    wb_we = 1; wb_dest = 12; tick();
    idle(); #1;
    total++;
    if (sb_err !== 1'b1) begin
      bad++; $display("FAIL uf_set got=%b exp=1", sb_err);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int busy_r;
      idle();
      busy_r = 0;
      for (int r = 1; r < 8; r++)
        if (m_cnt[r] != 0 && $urandom_range(0, 1) == 1) busy_r = r;
      issue      = $urandom_range(0, 1);
      issue_we   = $urandom_range(0, 3) != 0;
      issue_dest = 5'($urandom_range(0, 7));
      issue_load = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        wb_we = 1;
        wb_dest = ($urandom_range(0, 15) == 0 || busy_r == 0)
                ? 5'($urandom_range(0, 7)) : 5'(busy_r);
      end
      ld_done      = $urandom_range(0, 3) == 0;
      ld_done_dest = 5'($urandom_range(0, 7));
      flush        = $urandom_range(0, 59) == 0;
      ds_valid     = $urandom_range(0, 3) != 0;
      rs_re        = $urandom_range(0, 3) != 0;
      rt_re        = $urandom_range(0, 3) != 0;
      rs_addr      = 5'($urandom_range(0, 7));
      rt_addr      = 5'($urandom_range(0, 7));
      #1;
      total++;
      if (rs_busy !== m_busy(rs_addr, rs_re)) begin
        bad++;
        $display("FAIL rnd%0d rs_busy got=%b exp=%b",
                 i, rs_busy, m_busy(rs_addr, rs_re));
      end
      total++;
      if (rt_busy !== m_busy(rt_addr, rt_re)) begin
        bad++;
        $display("FAIL rnd%0d rt_busy got=%b exp=%b",
                 i, rt_busy, m_busy(rt_addr, rt_re));
      end
      total++;
      if (ld_stall !== m_stall()) begin
        bad++;
        $display("FAIL rnd%0d ld_stall got=%b exp=%b",
                 i, ld_stall, m_stall());
      end
      total++;
      if (sb_err !== m_err) begin
        bad++;
        $display("FAIL rnd%0d sb_err got=%b exp=%b", i, sb_err, m_err);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_chain();
    test_simul();
    test_flush_reset();
    test_r0_re();
    test_overflow();
    test_underflow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
